// File: rtl/frame_receiver_with_parity_check_if.sv
// Interface bundling the word input stream and the completed-frame outputs of
// frame_receiver_with_parity_check.
//   master : upstream/consumer side (drives rx_*, observes frame outputs)
//   slave  : the receiver (samples rx_*, drives frame outputs)
// Signals:
//   rx_valid          word present this cycle
//   rx_data[8:0]      [7:0] data byte, [8] even-parity bit
//   frame_data_out    completed frame, byte i at [8i+7:8i]
//   parity_error_mask bit i set if byte i failed parity
//   frame_error       OR of parity_error_mask
//   frame_done        one-cycle pulse, frame outputs newly valid
//   frame_abort       one-cycle pulse, partial frame dropped on gap timeout
//   busy              a frame is partially received
interface frame_receiver_with_parity_check_if #(
    parameter int unsigned FRAME_LEN = 16
);
    logic                   rx_valid;
    logic [8:0]             rx_data;
    logic [8*FRAME_LEN-1:0] frame_data_out;
    logic [FRAME_LEN-1:0]   parity_error_mask;
    logic                   frame_error;
    logic                   frame_done;
    logic                   frame_abort;
    logic                   busy;

    modport master (
        output rx_valid,
        output rx_data,
        input  frame_data_out,
        input  parity_error_mask,
        input  frame_error,
        input  frame_done,
        input  frame_abort,
        input  busy
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output frame_data_out,
        output parity_error_mask,
        output frame_error,
        output frame_done,
        output frame_abort,
        output busy
    );
endinterface

// File: rtl/frame_receiver_with_parity_check.sv
// Receives 9-bit words (8 data bits + even parity), collects FRAME_LEN of them
// into one frame and presents the frame in parallel with a per-byte parity
// error mask, a frame_error summary and a one-cycle frame_done pulse.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    frame_receiver_with_parity_check_if.slave (see interface header)
//
// Parameters:
//   FRAME_LEN    bytes per frame, 2..16
//   GAP_TIMEOUT  idle cycles inside a frame that abort it (>= 1)
//
// Optional feature: define FRAME_TIMEOUT_EN to enable the inter-word gap
// timeout. Without it a partial frame waits indefinitely and frame_abort is 0.
module frame_receiver_with_parity_check #(
    parameter int unsigned FRAME_LEN   = 16,
    parameter int unsigned GAP_TIMEOUT = 8
) (
    input logic                               clk,
    input logic                               reset,
    frame_receiver_with_parity_check_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(FRAME_LEN);
    localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);

    if (FRAME_LEN < 2 || FRAME_LEN > 16 || GAP_TIMEOUT < 1) begin : g_bad_param
        $error("frame_receiver_with_parity_check: illegal FRAME_LEN or GAP_TIMEOUT");
    end

    typedef enum logic [0:0] {
        StIdle,
        StRecv
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [8*FRAME_LEN-1:0] cap_q, cap_d;
    logic [FRAME_LEN-1:0]   emask_q, emask_d;
    logic [8*FRAME_LEN-1:0] frame_data_q, frame_data_d;
    logic [FRAME_LEN-1:0]   perr_q, perr_d;
    logic                   frame_error_q, frame_error_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;

    // Capture buffer / mask with the current word merged in at cnt_q.
    logic [8*FRAME_LEN-1:0] cap_wr;
    logic [FRAME_LEN-1:0]   emask_wr;
    logic                   word_err;

    assign word_err = bus.rx_data[8] ^ (^bus.rx_data[7:0]);

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned GapW = $clog2(GAP_TIMEOUT + 1);

    logic [GapW-1:0] gap_q, gap_d;
    logic            frame_abort_q, frame_abort_d;
    logic            gap_expire;

    // The GAP_TIMEOUT-th consecutive idle cycle; a valid word always wins.
    assign gap_expire = (state_q == StRecv) && !bus.rx_valid &&
                        (gap_q == GapW'(GAP_TIMEOUT - 1));
`endif

    always_comb begin
        cap_wr   = cap_q;
        emask_wr = emask_q;
        for (int unsigned i = 0; i < FRAME_LEN; i++) begin
            if (cnt_q == CntW'(i)) begin
                cap_wr[8*i +: 8] = bus.rx_data[7:0];
                emask_wr[i]      = word_err;
            end
        end

        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_d         = cap_q;
        emask_d       = emask_q;
        frame_data_d  = frame_data_q;
        perr_d        = perr_q;
        frame_error_d = frame_error_q;
        frame_done_d  = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        frame_abort_d = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    // cnt_q is 0 here, so this is byte 0; never last since FRAME_LEN >= 2.
                    cap_d   = cap_wr;
                    emask_d = emask_wr;
                    cnt_d   = CntW'(1);
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (bus.rx_valid) begin
                    cap_d   = cap_wr;
                    emask_d = emask_wr;
                    if (cnt_q == LastIdx) begin
                        frame_data_d  = cap_wr;
                        perr_d        = emask_wr;
                        frame_error_d = |emask_wr;
                        frame_done_d  = 1'b1;
                        cnt_d         = '0;
                        state_d       = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                else if (gap_expire) begin
                    cnt_d         = '0;
                    state_d       = StIdle;
                    frame_abort_d = 1'b1;
                end
`endif
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRecv);

`ifdef FRAME_TIMEOUT_EN
        // Counts idle cycles only while a frame is open; any word or exit clears it.
        if ((state_q == StRecv) && !bus.rx_valid && !gap_expire) begin
            gap_d = gap_q + GapW'(1);
        end else begin
            gap_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            cap_q         <= '0;
            emask_q       <= '0;
            frame_data_q  <= '0;
            perr_q        <= '0;
            frame_error_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            gap_q         <= '0;
            frame_abort_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cap_q         <= cap_d;
            emask_q       <= emask_d;
            frame_data_q  <= frame_data_d;
            perr_q        <= perr_d;
            frame_error_q <= frame_error_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
`ifdef FRAME_TIMEOUT_EN
            gap_q         <= gap_d;
            frame_abort_q <= frame_abort_d;
`endif
        end
    end

    assign bus.frame_data_out    = frame_data_q;
    assign bus.parity_error_mask = perr_q;
    assign bus.frame_error       = frame_error_q;
    assign bus.frame_done        = frame_done_q;
    assign bus.busy              = busy_q;
`ifdef FRAME_TIMEOUT_EN
    assign bus.frame_abort       = frame_abort_q;
`else
    assign bus.frame_abort       = 1'b0;
`endif

endmodule
